fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF stage of the 5-stage pipeline (IF ID EXE MEM WB).
- Owns the 8-bit program counter and drives the instruction memory's byte address.
- Takes the decoded fields (opcode/rt/rs/aux) back from that memory and registers them into the IF/ID pipeline register with a valid bit, the fetch PC and a retired-fetch counter.
- Handles stall, branch redirect/flush and a HALT word.

Parameters:
- ADDR_W, 8, program counter / instruction address width (256-byte program space).
- HALT_WORD, 8'hFF, instruction byte that stops fetch ({aux,rs,rt,opcode} = 3'b111,1,1,3'b111).
- CNT_W, 16, width of the fetch counter.

Ports:
- sysclk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- stall  in  1  ID stage cannot accept; hold PC and IF/ID.
- redirect  in  1  branch/jump taken in a later stage; load PC, flush IF/ID.
- redirect_pc  in  ADDR_W  target address for redirect.
- imem_addr  out  ADDR_W  address to instruction memory, = pc (combinational).
- imem_opcode  in  3  opcode field returned by instruction memory for imem_addr.
- imem_rt  in  1  rt field from instruction memory.
- imem_rs  in  1  rs field from instruction memory.
- imem_aux  in  3  aux field from instruction memory.
- id_valid  out  1  IF/ID holds a live instruction.
- id_opcode  out  3  registered opcode.
- id_rt  out  1  registered rt.
- id_rs  out  1  registered rs.
- id_aux  out  3  registered aux.
- id_pc  out  ADDR_W  address the IF/ID instruction was fetched from.
- halted  out  1  HALT word fetched; fetch frozen.
- fetch_count  out  CNT_W  number of instructions loaded into IF/ID with valid=1.

Behaviour:
- Memory read is combinational: fields on imem_* correspond to imem_addr in the same cycle.
- inst = {imem_aux, imem_rs, imem_rt, imem_opcode}.
- Reset (reset_n=0 at edge), overriding all other inputs including mid-stall and mid-redirect: pc=0, id_valid=0, id_opcode=0, id_rt=0, id_rs=0, id_aux=0, id_pc=0, halted=0, fetch_count=0.
- Per-edge priority after reset: redirect > stall > halted > normal fetch.
- Redirect (regardless of stall/halted):
  - pc <= redirect_pc, id_valid <= 0, halted <= 0.
  - Other id_* fields hold.
  - fetch_count unchanged.
- Stall (no redirect): pc, all id_* outputs, halted and fetch_count hold.
- Halted (no redirect, no stall): pc holds, id_valid <= 0, id_* fields hold.
- Normal fetch:
  - id_* fields <= imem_* fields, id_pc <= pc, id_valid <= 1.
  - fetch_count <= fetch_count+1, saturating at all-ones.
  - If inst == HALT_WORD: halted <= 1 and pc holds. The HALT itself is delivered to ID with valid=1.
  - Otherwise pc <= pc+1, modulo 2^ADDR_W (8'hFF -> 8'h00 wraps, no flag).
- Latency: instruction at address A appears on id_* one cycle after pc==A with no stall.
- Throughput: one instruction per cycle.
- redirect_pc is sampled only in the redirect cycle. The first fetch from the target lands in IF/ID on the next un-stalled edge, giving a 1-bubble penalty.
- Simultaneous stall+redirect: redirect wins; the IF/ID bubble is inserted even while stalled.
- halted is cleared only by reset or redirect.

Test Plan:
- Reset then run with mem[0..3]=8'h01,8'h0A,8'h13,8'h24, stall=0:
  - id_pc 0,1,2,3 on consecutive cycles.
  - Cycle 1: id_opcode=1, id_rt=0, id_rs=0, id_aux=0.
  - Cycle 2: id_opcode=2, id_rt=1.
  - fetch_count=4 after 4 fetches.
- Stall held 3 cycles at pc=2: imem_addr stays 2, id_pc stays 1, id_valid stays 1, fetch_count unchanged.
  - Release: next edge loads addr-2 instruction.
- Redirect to 8'h40 while pc=5, with stall=1 the same cycle:
  - Next cycle: pc=8'h40, id_valid=0.
  - Following un-stalled edge: id_pc=8'h40, id_valid=1.
- mem[6]=8'hFF:
  - After fetch: id_pc=6, id_valid=1, halted=1, pc stays 6.
  - Subsequent cycles: id_valid=0, fetch_count frozen.
  - Redirect to 8'h10 clears halted and resumes from 8'h10.
- Redirect to 8'hFE, mem[FE]/mem[FF] non-HALT, mem[00]=8'h01: id_pc sequence FE, FF, 00 with no flag or stall.
- Assert reset_n=0 mid-stall and mid-halt: next edge all outputs zero; fetch restarts from address 0 after release.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// IF stage of the 5-stage pipeline (IF ID EXE MEM WB). It owns the program
// counter and presents it to a combinational instruction memory. The decoded
// fields come back in the same cycle and are captured in the IF/ID pipeline
// register, together with a valid bit, the fetch PC and a count of the
// instructions retired into IF/ID.
//
// Ports
//   sysclk        in   rising-edge clock for all state
//   reset_n       in   synchronous active-low reset
//   stall         in   ID cannot accept: hold PC and IF/ID
//   redirect      in   taken branch/jump: load redirect_pc, flush IF/ID
//   redirect_pc   in   redirect target (sampled only while redirect=1)
//   imem_addr     out  byte address to instruction memory (= pc)
//   imem_opcode   in   opcode field for imem_addr
//   imem_rt       in   rt field for imem_addr
//   imem_rs       in   rs field for imem_addr
//   imem_aux      in   aux field for imem_addr
//   id_valid      out  IF/ID holds a live instruction
//   id_opcode     out  registered opcode
//   id_rt         out  registered rt
//   id_rs         out  registered rs
//   id_aux        out  registered aux
//   id_pc         out  address the IF/ID instruction came from
//   halted        out  HALT word fetched; fetch frozen until redirect/reset
//   fetch_count   out  saturating count of valid loads into IF/ID
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [7:0]  HALT_WORD = 8'hFF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              sysclk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [2:0]        imem_opcode,
  input  logic              imem_rt,
  input  logic              imem_rs,
  input  logic [2:0]        imem_aux,
  output logic              id_valid,
  output logic [2:0]        id_opcode,
  output logic              id_rt,
  output logic              id_rs,
  output logic [2:0]        id_aux,
  output logic [ADDR_W-1:0] id_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  logic [ADDR_W-1:0] pc;
  logic [7:0]        inst;
  logic              is_halt;

  // Instruction byte as laid out in memory: {aux, rs, rt, opcode}.
  assign inst      = {imem_aux, imem_rs, imem_rt, imem_opcode};
  assign is_halt   = (inst == HALT_WORD);
  assign imem_addr = pc;

  // Priority per edge: reset > redirect > stall > halted > normal fetch.
  // NOTE: every register here is real pipeline state, so all of them are
  // reset; a synchronous reset lets it override redirect/stall cleanly.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      pc          <= '0;
      id_valid    <= 1'b0;
      id_opcode   <= '0;
      id_rt       <= 1'b0;
      id_rs       <= 1'b0;
      id_aux      <= '0;
      id_pc       <= '0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else if (redirect) begin
      // Flush wins even during a stall; the id_* payload is left as-is
      // because the cleared valid bit already marks it dead.
      pc       <= redirect_pc;
      id_valid <= 1'b0;
      halted   <= 1'b0;
    end else if (stall) begin
      // Hold everything.
    end else if (halted) begin
      id_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge pc (id_pc gets the old pc while pc advances).
      id_opcode <= imem_opcode;
      id_rt     <= imem_rt;
      id_rs     <= imem_rs;
      id_aux    <= imem_aux;
      id_pc     <= pc;
      id_valid  <= 1'b1;
      if (fetch_count != '1) begin
        fetch_count <= fetch_count + 1'b1;
      end
      // The HALT word itself is delivered to ID; only the PC freezes.
      if (is_halt) begin
        halted <= 1'b1;
      end else begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule
